sifh_readout: RTL and testbench

SIFH_READOUT -- requirements
Module: sifh_readout

---
 rtl/sifh_readout_pkg.sv | 30 +++
 rtl/sifh_readout_peak_cmp.sv | 36 +++
 rtl/sifh_readout.sv | 145 ++++++++++++++
 tb/tb_sifh_readout.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sifh_readout_pkg.sv
// Shared SiFH histogram constants: default geometry, address split and readout states.
// Latency: none (types, constants and a helper function only).
// Backpressure: not applicable.
package sifh_readout_pkg;

   // Default geometry, shared with the histogram writer FSM.
   localparam int SIFH_NP  = 10;  // timestamp / bin-index width
   localparam int SIFH_PIX = 2;   // histograms per RAM
   localparam int SIFH_CW  = 8;   // bin count width (saturating peak value)

   // Pixel-index width. It is never narrower than one bit, so a single-histogram
   // RAM still has a well-formed {pixel, bin} address.
   function automatic int sifhPixBits(input int pix);
      return (pix > 1) ? $clog2(pix) : 1;
   endfunction

   // RAM address width for a given geometry: {pixel, bin}.
   function automatic int sifhAddrBits(input int pix, input int np);
      return sifhPixBits(pix) + np;
   endfunction

   // Readout sequencer states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      DRAIN  = 2'd2,
      REPORT = 2'd3
   } rdState_t;

endpackage

// File: rtl/sifh_readout_peak_cmp.sv
// Running maximum over one histogram: keeps the largest count and the bin it came from.
// Latency: one cycle from a valid data word to the updated max/maxBin.
// Backpressure: none; every valid word is consumed in the cycle it arrives.
module sifh_peak_cmp
   import sifh_readout_pkg::*;
#(
   parameter int Np = SIFH_NP,
   parameter int CW = SIFH_CW
)(
   input  logic          clk,
   input  logic          res,
   input  logic          clear,
   input  logic          valid,
   input  logic [CW-1:0] data,
   input  logic [Np-1:0] bin,
   output logic [CW-1:0] max,
   output logic [Np-1:0] maxBin
);

   // Track the running max. Only a strictly greater count replaces it, so when
   // counts tie the earliest (lowest) bin is kept. A saturated count is an
   // ordinary value here: the compare is plain unsigned, no arithmetic on data.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         max    <= '0;
         maxBin <= '0;
      end else if (clear) begin
         max    <= '0;
         maxBin <= '0;
      end else if (valid && (data > max)) begin
         max    <= data;
         maxBin <= bin;
      end
   end

endmodule

// File: rtl/sifh_readout.sv
// Post-acquisition histogram readout: read-and-clear every bin, report the peak of each pixel.
// Latency: peakValid rises 2^Np+1 cycles after the first read address of a pixel.
// Backpressure: result is held in REPORT until peakReady; RAM traffic stops while waiting.
module sifh_readout
   import sifh_readout_pkg::*;
#(
   parameter  int Np  = SIFH_NP,
   parameter  int PIX = SIFH_PIX,
   parameter  int CW  = SIFH_CW,
   localparam int PL  = sifhPixBits(PIX),
   localparam int NB  = sifhAddrBits(PIX, Np)
)(
   input  logic          clk,
   input  logic          res,
   input  logic          start,
   output logic [NB-1:0] raddr,
   output logic          readFlag,
   input  logic [CW-1:0] counts,
   output logic [NB-1:0] waddr,
   output logic          writeFlag,
   output logic          wEnable,
   output logic          busy,
   output logic          peakValid,
   input  logic          peakReady,
   output logic [PL-1:0] peakPix,
   output logic [Np-1:0] peakBin,
   output logic [CW-1:0] peakCount,
   output logic          noPeak
);

   rdState_t      state;
   rdState_t      stateNxt;
   logic [PL-1:0] pixCnt;
   logic [Np-1:0] binCnt;
   logic          rdVld;    // counts carries data for rdAddr this cycle
   logic [NB-1:0] rdAddr;   // address whose data is arriving now
   logic          lastBin;
   logic          lastPix;
   logic          handshake;
   logic          clearMax;
   logic [CW-1:0] maxCount;
   logic [Np-1:0] maxBin;

   assign lastBin   = (binCnt == {Np{1'b1}});
   assign lastPix   = (pixCnt == PL'(PIX - 1));
   assign handshake = (state == REPORT) && peakReady;

   // A fresh pixel starts either from an accepted start or from a handshake
   // that moves on to the next pixel; the running max restarts at zero then.
   assign clearMax  = ((state == IDLE) && start) || (handshake && !lastPix);

   // Sequencer state register.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state <= IDLE;
      end else begin
         state <= stateNxt;
      end
   end

   // Next-state: sweep all bins, one idle cycle for the last word, then wait
   // for the consumer. start is only looked at in IDLE, peakReady only in REPORT.
   always_comb begin
      stateNxt = state;
      case (state)
         IDLE:    if (start)     stateNxt = READ;
         READ:    if (lastBin)   stateNxt = DRAIN;
         DRAIN:                  stateNxt = REPORT;
         REPORT:  if (handshake) stateNxt = lastPix ? IDLE : READ;
         default:                stateNxt = IDLE;
      endcase
   end

   // Pixel and bin counters. The bin counter wraps back to zero after the last
   // bin, so the next pixel always starts at bin 0 without extra logic.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         pixCnt <= '0;
         binCnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               pixCnt <= '0;
               binCnt <= '0;
            end
            READ: begin
               binCnt <= binCnt + 1'b1;
            end
            REPORT: begin
               if (handshake) begin
                  pixCnt <= lastPix ? '0 : pixCnt + 1'b1;
               end
            end
            default: begin
               binCnt <= '0;
            end
         endcase
      end
   end

   // Remember which address was read so its data can be compared and the same
   // word cleared one cycle later. The read address has already moved on by
   // then, so read and clear never collide.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         rdVld  <= 1'b0;
         rdAddr <= '0;
      end else begin
         rdVld  <= readFlag;
         rdAddr <= readFlag ? raddr : '0;
      end
   end

   sifh_peak_cmp #(
      .Np (Np),
      .CW (CW)
   ) uPeakCmp (
      .clk    (clk),
      .res    (res),
      .clear  (clearMax),
      .valid  (rdVld),
      .data   (counts),
      .bin    (rdAddr[Np-1:0]),
      .max    (maxCount),
      .maxBin (maxBin)
   );

   // RAM ports: port b reads in READ only; port a clears the word that just
   // arrived. IDLE and REPORT leave both ports quiet.
   assign readFlag  = (state == READ);
   assign raddr     = readFlag ? {pixCnt, binCnt} : '0;
   assign writeFlag = rdVld;
   assign wEnable   = rdVld;
   assign waddr     = rdAddr;

   // Result fields are only meaningful in REPORT; elsewhere they read as zero.
   // The max register cannot change in REPORT, so the fields hold until accepted.
   assign busy      = (state != IDLE);
   assign peakValid = (state == REPORT);
   assign peakPix   = peakValid ? pixCnt : '0;
   assign peakBin   = peakValid ? maxBin : '0;
   assign peakCount = peakValid ? maxCount : '0;
   assign noPeak    = peakValid && (maxCount == '0);

endmodule

// File: tb/tb_sifh_readout.sv
// Bench for sifh_readout with Np=3, PIX=2, CW=4 and a behavioural dual-port RAM.
// Latency: checks 9-cycle read-to-result timing and next-pixel issue after a handshake.
// Backpressure: holds peakReady low for several cycles and checks the held result.
module tb_sifh_readout;
   localparam int Np  = 3;
   localparam int PIX = 2;
   localparam int CW  = 4;
   localparam int PL  = 1;
   localparam int NB  = 4;
   localparam int NW  = 16;
   localparam int BPP = 8;   // bins per pixel

   typedef struct {
      logic [63:0] img;
      int          bin0;
      int          cnt0;
      bit          no0;
      int          bin1;
      int          cnt1;
      bit          no1;
      int          hold;
   } vec_t;

   logic          clk;
   logic          res;
   logic          start;
   logic [NB-1:0] raddr;
   logic          readFlag;
   logic [CW-1:0] counts;
   logic [NB-1:0] waddr;
   logic          writeFlag;
   logic          wEnable;
   logic          busy;
   logic          peakValid;
   logic          peakReady;
   logic [PL-1:0] peakPix;
   logic [Np-1:0] peakBin;
   logic [CW-1:0] peakCount;
   logic          noPeak;

   logic [CW-1:0] mem [NW];
   logic [63:0]   loadImg;
   logic          loadEn;
   logic          collide;
   logic          enBad;
   logic [21:0]   outVec;

   int total = 0;
   int bad   = 0;
   vec_t vecs [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sifh_readout #(.Np(Np), .PIX(PIX), .CW(CW)) dut (
      .clk       (clk),
      .res       (res),
      .start     (start),
      .raddr     (raddr),
      .readFlag  (readFlag),
      .counts    (counts),
      .waddr     (waddr),
      .writeFlag (writeFlag),
      .wEnable   (wEnable),
      .busy      (busy),
      .peakValid (peakValid),
      .peakReady (peakReady),
      .peakPix   (peakPix),
      .peakBin   (peakBin),
      .peakCount (peakCount),
      .noPeak    (noPeak)
   );

   assign outVec = {raddr, waddr, readFlag, writeFlag, wEnable, busy, peakValid,
                    peakPix, peakBin, peakCount, noPeak};

   // RAM model plus monitors for same-address collisions and stray enables.
   always @(posedge clk) begin
      if (loadEn) begin
         for (int i = 0; i < NW; i++) mem[i] <= loadImg[4*i +: 4];
         collide <= 1'b0;
         enBad   <= 1'b0;
      end else begin
         if (readFlag) counts <= mem[raddr];
         if (writeFlag && wEnable) mem[waddr] <= '0;
         if (readFlag && writeFlag && (raddr == waddr)) collide <= 1'b1;
         if ((!busy || peakValid) && (readFlag || writeFlag || wEnable)) enBad <= 1'b1;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] setW(input logic [63:0] img, input int idx, input logic [3:0] val);
      logic [63:0] r;
      r = img;
      r[4*idx +: 4] = val;
      return r;
   endfunction

   // Reference: the peak is the largest count of the pixel, reported at the
   // first bin holding it; a pixel of all zeros reports no peak.
   task automatic refPeak(input logic [63:0] img, input int p,
                          output int b, output int c, output bit np);
      int vals [BPP];
      int top;
      for (int i = 0; i < BPP; i++) vals[i] = int'(img[4*(p*BPP + i) +: 4]);
      top = 0;
      foreach (vals[i]) if (vals[i] > top) top = vals[i];
      b = 0;
      for (int i = BPP - 1; i >= 0; i--) if (vals[i] == top) b = i;
      c  = top;
      np = (top == 0);
   endtask

   task automatic loadMem(input logic [63:0] img);
      loadImg = img;
      loadEn  = 1'b1;
      tick();
      loadEn  = 1'b0;
   endtask

   task automatic runPass(input vec_t v, input bit midStart);
      int n;
      int eb;
      int ec;
      bit en;
      bit stable;
      logic [21:0] held;
      logic [63:0] leftover;
      loadMem(v.img);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busyAfterStart", busy, 1);
      for (int p = 0; p < PIX; p++) begin
         eb = (p == 0) ? v.bin0 : v.bin1;
         ec = (p == 0) ? v.cnt0 : v.cnt1;
         en = (p == 0) ? v.no0  : v.no1;
         check("firstRead", {readFlag, raddr}, {1'b1, 4'(p*BPP)});
         n = 0;
         while (!peakValid && n < 100) begin
            tick();
            n++;
            start = (midStart && p == 0 && n == 3);
         end
         start = 1'b0;
         check("latency", n, 9);
         check("peakPix", peakPix, p);
         check("peakBin", peakBin, eb);
         check("peakCount", peakCount, ec);
         check("noPeak", noPeak, en);
         if (v.hold > 0) begin
            held   = outVec;
            stable = 1'b1;
            for (int h = 0; h < v.hold; h++) begin
               tick();
               if (outVec !== held || !peakValid || readFlag || writeFlag || wEnable) stable = 1'b0;
            end
            check("holdStable", stable, 1);
         end
         peakReady = 1'b1;
         tick();
         peakReady = 1'b0;
         if (p < PIX - 1)
            check("nextPixRead", {peakValid, readFlag, raddr}, {1'b0, 1'b1, 4'((p+1)*BPP)});
         else
            check("doneIdle", {busy, peakValid, readFlag}, 0);
      end
      n = 0;
      repeat (20) begin
         tick();
         if (busy || readFlag) n++;
      end
      check("singlePass", n, 0);
      leftover = '0;
      for (int i = 0; i < NW; i++) leftover[4*i +: 4] = mem[i];
      check("ramCleared", leftover, 0);
      check("noCollide", collide, 0);
      check("quietIdleReport", enBad, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [63:0] img;
      logic [63:0] want;
      logic [63:0] got;
      vec_t        rv;
      int          r;

      res       = 1'b0;
      start     = 1'b0;
      peakReady = 1'b0;
      loadEn    = 1'b0;
      loadImg   = '0;
      tick();
      tick();
      check("resetOutputs", outVec, 0);
      res = 1'b1;
      tick();
      check("idleAfterReset", outVec, 0);

      // Directed table: spec-derived patterns and expected results.
      img = '0;
      for (int j = 0; j < BPP; j++) img = setW(img, j, 4'd1);
      img = setW(img, 5, 4'd7);
      vecs[0] = '{img: img, bin0: 5, cnt0: 7, no0: 0, bin1: 0, cnt1: 0, no1: 1, hold: 0};
      img = '0;
      img = setW(img, 2, 4'd9);
      img = setW(img, 6, 4'd9);
      for (int j = BPP; j < NW; j++) img = setW(img, j, 4'd15);
      vecs[1] = '{img: img, bin0: 2, cnt0: 9, no0: 0, bin1: 0, cnt1: 15, no1: 0, hold: 5};
      img = '0;
      img = setW(img, 7, 4'd15);
      img = setW(img, 8, 4'd1);
      vecs[2] = '{img: img, bin0: 7, cnt0: 15, no0: 0, bin1: 0, cnt1: 1, no1: 0, hold: 0};
      img = '0;
      vecs[3] = '{img: img, bin0: 0, cnt0: 0, no0: 1, bin1: 0, cnt1: 0, no1: 1, hold: 2};

      for (int i = 0; i < 4; i++) runPass(vecs[i], (i == 3));

      // Reset in the middle of pixel 0, while bin 4 is being addressed.
      img = '0;
      for (int j = 0; j < NW; j++) img = setW(img, j, 4'((j % 15) + 1));
      loadMem(img);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("rstAtBin4", {readFlag, raddr}, {1'b1, 4'd4});
      #1 res = 1'b0;
      #1;
      check("rstOutputsZero", outVec, 0);
      tick();
      res = 1'b1;
      tick();
      want = img;
      for (int j = 0; j < 3; j++) want = setW(want, j, 4'd0);
      got = '0;
      for (int j = 0; j < NW; j++) got[4*j +: 4] = mem[j];
      check("rstPartialClear", got, want);
      check("rstIdle", busy, 0);

      // Randomised passes against the reference model.
      for (int k = 0; k < 6; k++) begin
         img = '0;
         for (int j = 0; j < NW; j++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0)      img = setW(img, j, 4'd0);
            else if (r == 1) img = setW(img, j, 4'd15);
            else             img = setW(img, j, 4'($urandom_range(0, 15)));
            if (k == 2 && j >= BPP) img = setW(img, j, 4'd0);
         end
         rv.img  = img;
         rv.hold = int'($urandom_range(0, 3));
         refPeak(img, 0, rv.bin0, rv.cnt0, rv.no0);
         refPeak(img, 1, rv.bin1, rv.cnt1, rv.no1);
         runPass(rv, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
